traffic_timer: RTL and testbench
================================

TRAFFIC_TIMER -- requirements
Module: traffic_timer

Interface
REQ-001 The block SHALL have parameters, one per line: name, default, meaning:
- TICK_DIV, 50000000: CLOCK_50 cycles per timer tick (1 s at 50 MHz); legal range 2..2^26.
- LONG_VAL, 20: reload value when twentyToLoad=1; legal range 6..31.
- SHORT_VAL, 3: reload value when twentyToLoad=0; legal range 1..31.
REQ-002 The block SHALL have ports, one per line: name, direction, width, meaning:
- CLOCK_50  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- load  in  1  from control unit; reload counter and hold prescaler.
- twentyToLoad  in  1  from control unit; selects LONG_VAL (1) or SHORT_VAL (0).
- counterNotZero  out  1  high when count != 0.
- counterNotFive  out  1  high when count != 5.
- tick  out  1  one-cycle pulse at each prescaler terminal count.
- count  out  5  remaining seconds, registered.
- tens  out  4  BCD tens digit of count.
- ones  out  4  BCD ones digit of count.
REQ-003 Reset SHALL be one clock, synchronous, active-high, sampled only on the CLOCK_50 rising edge.

Function
REQ-004 The prescaler SHALL be a 26-bit register counting 0..TICK_DIV-1 and wrapping to 0.
REQ-005 tick SHALL be high for exactly the cycle in which the prescaler equals TICK_DIV-1 and load=0.
REQ-006 While load=1, the prescaler SHALL be held at 0 and tick SHALL be 0.
REQ-007 While load=1, count SHALL be written each cycle with LONG_VAL if twentyToLoad=1, else SHORT_VAL.
REQ-008 While load=0, count SHALL decrement by 1 on each cycle in which tick=1 and count != 0.
REQ-009 count SHALL saturate at 0; no wrap to 31; the prescaler keeps running while count=0.
REQ-010 The first decrement after load falls SHALL occur exactly TICK_DIV cycles after the first cycle with load=0.
REQ-011 When load and a prescaler terminal count coincide, load SHALL win: reload occurs and no decrement occurs.
REQ-012 counterNotZero and counterNotFive SHALL be combinational decodes of the count register only, with no extra latency.
REQ-013 tens and ones SHALL be combinational: tens = count/10 (0..3), ones = count mod 10.
REQ-014 A change of twentyToLoad while load=0 SHALL have no effect.

Reset
REQ-015 On reset=1, the block SHALL set: prescaler=0, count=0, tick=0, counterNotZero=0, counterNotFive=1, tens=0, ones=0.
REQ-016 reset SHALL take priority over load and tick, including mid-countdown.
REQ-017 After reset, the block SHALL stay at count=0 until the first load.

Verification (TICK_DIV=4 for all scenarios)
REQ-018 Reset check: assert reset 2 cycles -> count=0, counterNotZero=0, counterNotFive=1, tick=0, tens=0, ones=0.
REQ-019 Long load: load=1, twentyToLoad=1 for 1 cycle, then load=0 ->
- count=20, tens=2, ones=0 on the next edge.
- count=19 at 4 cycles after load falls.
- counterNotFive=0 at 60 cycles, with tens=0, ones=5.
- counterNotZero=0 at 80 cycles.
- count then holds at 0.
REQ-020 Short load: load=1, twentyToLoad=0 for 1 cycle -> count=3; count=0 after 12 cycles; tick keeps pulsing every 4 cycles; count stays 0.
REQ-021 Reload mid-count: during long countdown at count=12, pulse load with twentyToLoad=0 on a tick cycle -> count=3, no decrement that cycle, next decrement exactly 4 cycles after load falls.
REQ-022 Reset mid-count: assert reset at count=9 -> next edge count=0, prescaler=0, counterNotZero=0; a held load is ignored while reset=1.
REQ-023 Held load: hold load=1 for 10 cycles -> count stays 20, tick never asserts, prescaler stays 0.

Source files
------------

// File: rtl/traffic_timer.sv
// Countdown timer for a traffic-light controller: a free-running prescaler
// produces a one-cycle tick, and a 5-bit seconds counter reloads on load and saturates at zero.
module traffic_timer #(
  parameter int TICK_DIV  = 50000000,
  parameter int LONG_VAL  = 20,
  parameter int SHORT_VAL = 3
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       load,
  input  logic       twentyToLoad,
  output logic       counterNotZero,
  output logic       counterNotFive,
  output logic       tick,
  output logic [4:0] count,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  localparam logic [25:0] TERM      = 26'(TICK_DIV - 1);
  localparam logic [4:0]  LONG_CNT  = 5'(LONG_VAL);
  localparam logic [4:0]  SHORT_CNT = 5'(SHORT_VAL);

  logic [25:0] prescaler_q, prescaler_d;
  logic [4:0]  count_q, count_d;
  logic [4:0]  ones_wide;

  // Reset is gated in so tick is never seen while the block is being cleared.
  assign tick = (prescaler_q == TERM) && !load && !reset;

  always_comb begin
    prescaler_d = prescaler_q + 26'd1;
    if (reset || load || (prescaler_q == TERM)) begin
      prescaler_d = 26'd0;
    end
  end

  always_comb begin
    count_d = count_q;
    if (reset) begin
      count_d = 5'd0;
    end else if (load) begin
      count_d = twentyToLoad ? LONG_CNT : SHORT_CNT;
    end else if (tick && (count_q != 5'd0)) begin
      count_d = count_q - 5'd1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    prescaler_q <= prescaler_d;
    count_q     <= count_d;
  end

  assign count          = count_q;
  assign counterNotZero = (count_q != 5'd0);
  assign counterNotFive = (count_q != 5'd5);

  // Count never exceeds 31, so a three-step compare replaces a divider.
  always_comb begin
    tens      = 4'd0;
    ones_wide = count_q;
    if (count_q >= 5'd30) begin
      tens      = 4'd3;
      ones_wide = count_q - 5'd30;
    end else if (count_q >= 5'd20) begin
      tens      = 4'd2;
      ones_wide = count_q - 5'd20;
    end else if (count_q >= 5'd10) begin
      tens      = 4'd1;
      ones_wide = count_q - 5'd10;
    end
    ones = ones_wide[3:0];
  end

endmodule

// File: tb/tb_traffic_timer.sv
// Self-checking bench for traffic_timer with TICK_DIV=4: a closed-form model
// (loaded value minus elapsed whole ticks) checked every cycle, plus literal expectations.
module tb_traffic_timer;

  localparam int TD = 4;

  logic       clk;
  logic       reset;
  logic       load;
  logic       sel;
  logic       cnz;
  logic       cnf;
  logic       tick;
  logic [4:0] count;
  logic [3:0] tens;
  logic [3:0] ones;

  int vectors = 0;
  int miscompares = 0;

  // Model state: value loaded at the last reload and free-running cycles since then.
  int  base = 0;
  int  n = 0;
  bit  valid = 0;

  traffic_timer #(.TICK_DIV(TD), .LONG_VAL(20), .SHORT_VAL(3)) dut (
    .CLOCK_50      (clk),
    .reset         (reset),
    .load          (load),
    .twentyToLoad  (sel),
    .counterNotZero(cnz),
    .counterNotFive(cnf),
    .tick          (tick),
    .count         (count),
    .tens          (tens),
    .ones          (ones)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      base  <= 0;
      n     <= 0;
      valid <= 1'b1;
    end else if (load) begin
      base <= sel ? 20 : 3;
      n    <= 0;
    end else begin
      n <= n + 1;
    end
  end

  always @(negedge clk) begin
    int ec;
    int et;
    if (valid) begin
      ec = base - n / TD;
      if (ec < 0) ec = 0;
      et = (!reset && !load && (n % TD == TD - 1)) ? 1 : 0;
      chk("model_count", int'(count), ec);
      chk("model_tick", int'(tick), et);
      chk("model_not_zero", int'(cnz), (ec != 0) ? 1 : 0);
      chk("model_not_five", int'(cnf), (ec != 5) ? 1 : 0);
      chk("model_tens", int'(tens), ec / 10);
      chk("model_ones", int'(ones), ec % 10);
      chk("model_prescaler", int'(dut.prescaler_q), n % TD);
    end
  end

  task automatic cyc(input int k);
    repeat (k) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    reset = 1'b1;
    load  = 1'b0;
    sel   = 1'b0;
    cyc(2);
    reset = 1'b0;
    chk("reset_count", int'(count), 0);
    chk("reset_not_zero", int'(cnz), 0);
    chk("reset_not_five", int'(cnf), 1);
    chk("reset_tick", int'(tick), 0);
    chk("reset_tens", int'(tens), 0);
    chk("reset_ones", int'(ones), 0);
    cyc(5);
    chk("idle_after_reset_count", int'(count), 0);

    // Long load, with twentyToLoad toggled mid-countdown to show it is ignored.
    load = 1'b1; sel = 1'b1;
    cyc(1);
    load = 1'b0;
    chk("long_load_count", int'(count), 20);
    chk("long_load_tens", int'(tens), 2);
    chk("long_load_ones", int'(ones), 0);
    cyc(4);
    chk("long_first_dec", int'(count), 19);
    sel = 1'b0;
    cyc(56);
    chk("long_at_60_count", int'(count), 5);
    chk("long_at_60_not_five", int'(cnf), 0);
    chk("long_at_60_tens", int'(tens), 0);
    chk("long_at_60_ones", int'(ones), 5);
    cyc(20);
    chk("long_at_80_count", int'(count), 0);
    chk("long_at_80_not_zero", int'(cnz), 0);
    cyc(8);
    chk("long_hold_zero", int'(count), 0);

    // Short load, then ticks continue while count sits at zero.
    load = 1'b1; sel = 1'b0;
    cyc(1);
    load = 1'b0;
    chk("short_load_count", int'(count), 3);
    cyc(12);
    chk("short_at_12_count", int'(count), 0);
    cyc(3);
    chk("short_tick_at_zero", int'(tick), 1);
    cyc(1);
    chk("short_tick_gone", int'(tick), 0);
    chk("short_still_zero", int'(count), 0);

    // Reload on a tick cycle at count=12.
    load = 1'b1; sel = 1'b1;
    cyc(1);
    load = 1'b0;
    cyc(32);
    chk("reload_pre_count", int'(count), 12);
    cyc(3);
    chk("reload_pre_tick", int'(tick), 1);
    load = 1'b1; sel = 1'b0;
    #1;
    chk("reload_tick_masked", int'(tick), 0);
    cyc(1);
    load = 1'b0;
    chk("reload_count", int'(count), 3);
    cyc(3);
    chk("reload_no_early_dec", int'(count), 3);
    cyc(1);
    chk("reload_next_dec", int'(count), 2);

    // Reset at count=9 with load held.
    load = 1'b1; sel = 1'b1;
    cyc(1);
    load = 1'b0;
    cyc(44);
    chk("midreset_pre_count", int'(count), 9);
    reset = 1'b1; load = 1'b1;
    cyc(1);
    chk("midreset_count", int'(count), 0);
    chk("midreset_not_zero", int'(cnz), 0);
    cyc(1);
    chk("midreset_load_ignored", int'(count), 0);
    reset = 1'b0; load = 1'b0;
    cyc(2);
    chk("midreset_after", int'(count), 0);

    // Held load for 10 cycles.
    load = 1'b1; sel = 1'b1;
    cyc(10);
    chk("held_count", int'(count), 20);
    chk("held_tick", int'(tick), 0);
    load = 1'b0;
    cyc(4);
    chk("held_release_dec", int'(count), 19);

    cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
